// File: rtl/vram_writer.sv
// ---------------------------------------------------------------------------
// vram_writer
//
// Write-side controller for the 3-plane (R/G/B, 1 bit per plane) video frame
// buffer. It fills the same address space that the scan-out reader walks
// (0..PIXELS-1). There are two ways to fill it:
//   * a valid/ready pixel stream, started with i_frame_start;
//   * a single-colour fill of the whole frame, started with i_start_fill.
//
// Ports
//   i_clk          system clock, all logic on the rising edge
//   i_reset        synchronous, active-high reset
//   i_frame_start  begin (or restart) a streamed frame at address 0
//   i_start_fill   begin filling the whole frame with i_fill_color
//   i_fill_color   {R,G,B} fill colour, sampled on the i_start_fill cycle
//   i_pix_valid    i_pix_data holds a pixel
//   i_pix_data     {R,G,B} streamed pixel
//   o_pix_ready    block accepts a pixel this cycle (decoded from state)
//   o_wr_en        write strobe to all three planes
//   o_wr_addr      write address
//   o_wr_red       R plane write data
//   o_wr_green     G plane write data
//   o_wr_blue      B plane write data
//   o_busy         high while streaming or filling
//   o_frame_done   one-cycle pulse coincident with the final write of a frame
// ---------------------------------------------------------------------------
module vram_writer #(
    parameter int ADDR_W = 14,
    parameter int PIXELS = 12288
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_frame_start,
    input  logic              i_start_fill,
    input  logic [2:0]        i_fill_color,
    input  logic              i_pix_valid,
    input  logic [2:0]        i_pix_data,
    output logic              o_pix_ready,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic              o_wr_red,
    output logic              o_wr_green,
    output logic              o_wr_blue,
    output logic              o_busy,
    output logic              o_frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FILL   = 2'd2
    } state_t;

    // Terminal address: the frame ends on an explicit compare, never on wrap.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [2:0]        r_fill_color;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [2:0]        r_wr_rgb;
    logic              r_busy;
    logic              r_frame_done;

    logic              w_last;
    logic              w_accept;

    assign w_last      = (r_ptr == LAST_ADDR);
    assign o_pix_ready = (r_state == ST_STREAM);
    assign w_accept    = i_pix_valid && (r_state == ST_STREAM);

    assign o_wr_en      = r_wr_en;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_red     = r_wr_rgb[2];
    assign o_wr_green   = r_wr_rgb[1];
    assign o_wr_blue    = r_wr_rgb[0];
    assign o_busy       = r_busy;
    assign o_frame_done = r_frame_done;

    // Control FSM with registered write-port outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_fill_color <= 3'b000;
            r_wr_en      <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_rgb     <= 3'b000;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Strobes are single-cycle unless a branch below re-asserts them.
            r_wr_en      <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (i_start_fill) begin
                        // Fill has priority over a simultaneous frame_start.
                        r_fill_color <= i_fill_color;
                        r_ptr        <= '0;
                        r_state      <= ST_FILL;
                        r_busy       <= 1'b1;
                    end else if (i_frame_start) begin
                        r_ptr   <= '0;
                        r_state <= ST_STREAM;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end

                ST_STREAM: begin
                    if (i_frame_start) begin
                        // Restart: a pixel accepted on this same cycle is dropped.
                        r_ptr <= '0;
                    end else if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_ptr;
                        r_wr_rgb  <= i_pix_data;
                        if (w_last) begin
                            r_frame_done <= 1'b1;
                            r_ptr        <= '0;
                            r_state      <= ST_IDLE;
                            r_busy       <= 1'b0;
                        end else begin
                            r_ptr <= r_ptr + ADDR_W'(1);
                        end
                    end else begin
                        // Valid gap: hold the pointer so addresses stay contiguous.
                        r_ptr <= r_ptr;
                    end
                end

                ST_FILL: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_ptr;
                    r_wr_rgb  <= r_fill_color;
                    if (w_last) begin
                        r_frame_done <= 1'b1;
                        r_ptr        <= '0;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                    end else begin
                        r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vram_writer.sv
// ---------------------------------------------------------------------------
// tb_vram_writer
//
// Scoreboard bench for vram_writer. Stimulus tasks push the expected write
// (address, colour, frame_done flag, cycle of appearance) into a queue; a
// monitor on the falling edge pops and compares every write the DUT makes.
// ---------------------------------------------------------------------------
module tb_vram_writer;

    localparam int ADDR_W = 14;
    localparam int PIXELS = 12288;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [2:0]        rgb;
        logic              done;
        int                cyc;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              frame_start;
    logic              start_fill;
    logic [2:0]        fill_color;
    logic              pix_valid;
    logic [2:0]        pix_data;
    logic              pix_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_red;
    logic              wr_green;
    logic              wr_blue;
    logic              busy;
    logic              frame_done;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   wcount = 0;
    exp_t sb[$];
    exp_t mon_e;

    // Bench-side model of the stream pointer.
    bit   m_stream = 1'b0;
    int   m_ptr    = 0;

    vram_writer #(.ADDR_W(ADDR_W), .PIXELS(PIXELS)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_frame_start(frame_start),
        .i_start_fill (start_fill),
        .i_fill_color (fill_color),
        .i_pix_valid  (pix_valid),
        .i_pix_data   (pix_data),
        .o_pix_ready  (pix_ready),
        .o_wr_en      (wr_en),
        .o_wr_addr    (wr_addr),
        .o_wr_red     (wr_red),
        .o_wr_green   (wr_green),
        .o_wr_blue    (wr_blue),
        .o_busy       (busy),
        .o_frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            wcount <= wcount + 1;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d rgb=%b done=%b cyc=%0d, required no write",
                         wr_addr, {wr_red, wr_green, wr_blue}, frame_done, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (wr_addr !== mon_e.addr || {wr_red, wr_green, wr_blue} !== mon_e.rgb ||
                    frame_done !== mon_e.done || cyc != mon_e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr=%0d rgb=%b done=%b cyc=%0d, expected addr=%0d rgb=%b done=%b cyc=%0d",
                             wr_addr, {wr_red, wr_green, wr_blue}, frame_done, cyc,
                             mon_e.addr, mon_e.rgb, mon_e.done, mon_e.cyc);
                end
            end
        end else if (frame_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL frame_done_without_write: got 1 at cyc=%0d, expected 0", cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic push(input int addr, input logic [2:0] rgb, input logic done, input int at_cyc);
        exp_t e;
        e.addr = ADDR_W'(addr);
        e.rgb  = rgb;
        e.done = done;
        e.cyc  = at_cyc;
        sb.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_wr_en"},      32'(wr_en),      32'd0);
        check_val({tag, "_wr_addr"},    32'(wr_addr),    32'd0);
        check_val({tag, "_wr_rgb"},     32'({wr_red, wr_green, wr_blue}), 32'd0);
        check_val({tag, "_pix_ready"},  32'(pix_ready),  32'd0);
        check_val({tag, "_busy"},       32'(busy),       32'd0);
        check_val({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    endtask

    // Present one pixel after `gap` idle cycles; the model decides acceptance.
    task automatic send_pix(input logic [2:0] rgb, input int gap);
        for (int g = 0; g < gap; g++) tick();
        pix_valid = 1'b1;
        pix_data  = rgb;
        check_val("pix_ready", 32'(pix_ready), 32'(m_stream));
        if (m_stream) begin
            push(m_ptr, rgb, (m_ptr == PIXELS - 1), cyc + 1);
            if (m_ptr == PIXELS - 1) m_stream = 1'b0;
            m_ptr++;
        end
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic begin_stream();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_stream = 1'b1;
        m_ptr    = 0;
    endtask

    task automatic wait_drain(input string name, input int limit);
        int n = 0;
        while (sb.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        tick();
        check_val({name, "_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int w0;
        reset = 1'b1; frame_start = 1'b0; start_fill = 1'b0;
        fill_color = 3'b000; pix_valid = 1'b0; pix_data = 3'b000;

        // 1. Reset values, then idle with no writes.
        tick(); tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        w0 = wcount;
        for (int i = 0; i < 50; i++) tick();
        check_val("idle_writes", 32'(wcount - w0), 32'd0);
        check_val("idle_busy", 32'(busy), 32'd0);

        // 2. Full-frame fill with 3'b101, first write two edges after request.
        start_fill = 1'b1;
        fill_color = 3'b101;
        for (int i = 0; i < PIXELS; i++) push(i, 3'b101, (i == PIXELS - 1), cyc + 2 + i);
        tick();
        start_fill = 1'b0;
        fill_color = 3'b000;
        check_val("fill_busy", 32'(busy), 32'd1);
        check_val("fill_pix_ready", 32'(pix_ready), 32'd0);
        wait_drain("fill", PIXELS + 20);
        check_val("fill_after_busy", 32'(busy), 32'd0);
        check_val("fill_after_wr_en", 32'(wr_en), 32'd0);

        // 3. 100 pixels with valid gaps; start_fill mid-stream must be ignored.
        begin_stream();
        check_val("stream_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 100; i++) begin
            if (i == 50) start_fill = 1'b1;
            send_pix(3'(i * 5 + 3), i % 3);
            start_fill = 1'b0;
        end
        wait_drain("stream100", 50);
        check_val("stream100_still_ready", 32'(pix_ready), 32'd1);

        // 4. Restart from STREAM, then 12289 back-to-back pixels; the last is not written.
        begin_stream();
        for (int i = 0; i < PIXELS + 1; i++) send_pix(3'(i * 3 + 1), 0);
        wait_drain("full_stream", 50);
        check_val("full_stream_ready_after", 32'(pix_ready), 32'd0);
        check_val("full_stream_busy_after", 32'(busy), 32'd0);

        // 5. Restart after 500 pixels; a pixel on the restart cycle is dropped.
        begin_stream();
        for (int i = 0; i < 500; i++) send_pix(3'(i + 2), 0);
        frame_start = 1'b1;
        pix_valid   = 1'b1;
        pix_data    = 3'b111;
        tick();
        frame_start = 1'b0;
        pix_valid   = 1'b0;
        m_ptr = 0;
        send_pix(3'b011, 0);
        send_pix(3'b100, 1);
        send_pix(3'b110, 0);
        wait_drain("restart", 50);

        // Leave STREAM cleanly through a reset before the next test.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_stream = 1'b0;
        check_reset_outputs("stream_reset");

        // 6. start_fill + frame_start together -> FILL; reset when addr 3000 is on the bus.
        start_fill  = 1'b1;
        frame_start = 1'b1;
        fill_color  = 3'b010;
        for (int i = 0; i <= 3000; i++) push(i, 3'b010, 1'b0, cyc + 2 + i);
        tick();
        start_fill  = 1'b0;
        frame_start = 1'b0;
        check_val("both_busy", 32'(busy), 32'd1);
        check_val("both_pix_ready", 32'(pix_ready), 32'd0);
        for (int i = 0; i < 3001; i++) begin
            tick();
            if (i % 1000 == 500) check_val("both_fill_pix_ready", 32'(pix_ready), 32'd0);
        end
        check_val("addr_at_reset", 32'(wr_addr), 32'd3000);
        reset = 1'b1;
        tick();
        check_reset_outputs("mid_fill_reset");
        reset = 1'b0;
        tick();
        check_val("post_reset_busy", 32'(busy), 32'd0);
        check_val("post_reset_pix_ready", 32'(pix_ready), 32'd0);
        wait_drain("mid_fill", 5);
        w0 = wcount;
        for (int i = 0; i < 10; i++) tick();
        check_val("post_reset_writes", 32'(wcount - w0), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
